// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the up/down counter sequencer: state encoding and default pacing.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN_UP   = 2'b01,
        ST_RUN_DOWN = 2'b10
    } state_e;

    localparam int unsigned DEFAULT_PRESCALE = 100000000;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detect for one raw push-button.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_c
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic [2:0] settle_q, settle_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        settle_d = {settle_q[1:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            settle_q <= 3'b000;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            settle_q <= settle_d;
        end
    end

    // Blank edges until prev holds a post-reset sample, so a button held through reset is not a press.
    assign press_c = sync2_q & ~prev_q & settle_q[2];

endmodule

// File: rtl/counter_seq_ctrl.sv
// Turns up/down/stop buttons into paced, mutually exclusive one-cycle strobes for the up/down counter.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE   = DEFAULT_PRESCALE,
    parameter int unsigned CNT_W      = 4,
    parameter bit          LIMIT_STOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_stop,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             up,
    output logic             down,
    output logic [1:0]       state_o,
    output logic             busy
);

    localparam int unsigned      PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic press_up_c, press_down_c, press_stop_c;
    logic at_limit_c;

    state_e          state_q, state_d;
    logic [PS_W-1:0] pre_q,   pre_d;
    logic            tick_q,  tick_d;
    logic            up_q,    up_d;
    logic            down_q,  down_d;
    logic            busy_q,  busy_d;

    btn_sync_edge u_sync_up   (.clk(clk), .rst(rst), .btn_raw(btn_up),   .press_c(press_up_c));
    btn_sync_edge u_sync_down (.clk(clk), .rst(rst), .btn_raw(btn_down), .press_c(press_down_c));
    btn_sync_edge u_sync_stop (.clk(clk), .rst(rst), .btn_raw(btn_stop), .press_c(press_stop_c));

    assign at_limit_c = (state_q == ST_RUN_UP) ? (cnt_q == CNT_MAX) : (cnt_q == '0);

    // Next state, prescaler and strobes; the registered tick delays each strobe decision by one cycle.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        up_d    = 1'b0;
        down_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pre_d = '0;
                if (!press_stop_c) begin
                    if (press_up_c) begin
                        state_d = ST_RUN_UP;
                    end else if (press_down_c) begin
                        state_d = ST_RUN_DOWN;
                    end
                end
            end
            ST_RUN_UP, ST_RUN_DOWN: begin
                if (press_stop_c) begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end else if (state_q == ST_RUN_UP && press_down_c && !press_up_c) begin
                    state_d = ST_RUN_DOWN;
                    pre_d   = '0;
                end else if (state_q == ST_RUN_DOWN && press_up_c) begin
                    state_d = ST_RUN_UP;
                    pre_d   = '0;
                end else begin
                    pre_d  = (pre_q == PS_LAST) ? '0 : pre_q + PS_W'(1);
                    tick_d = (pre_q == PS_LAST);
                    if (tick_q) begin
                        if (LIMIT_STOP && at_limit_c) begin
                            state_d = ST_IDLE;
                            pre_d   = '0;
                            tick_d  = 1'b0;
                        end else begin
                            up_d   = (state_q == ST_RUN_UP);
                            down_d = (state_q == ST_RUN_DOWN);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            up_q    <= up_d;
            down_q  <= down_d;
            busy_q  <= busy_d;
        end
    end

    assign up      = up_q;
    assign down    = down_q;
    assign state_o = state_q;
    assign busy    = busy_q;

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the 4-bit up/down T-flip-flop counter. Converts three raw Basys3 push-buttons (up, down, stop) into paced, mutually exclusive one-cycle up/down strobes. Optionally halts at the count limits using the counter's Q fed back in. Sits between the board I/O and the counter instance in the top level.

Parameters:
PRESCALE, 100000000, clk cycles between strobes (1 Hz at 100 MHz); legal range >= 2; benches use 4
CNT_W, 4, width of the counter feedback
LIMIT_STOP, 1, 1 = stop at 0/max; 0 = let the counter wrap

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
btn_up  input  1  raw up button (asynchronous, level)
btn_down  input  1  raw down button (asynchronous, level)
btn_stop  input  1  raw stop button (asynchronous, level)
cnt_q  input  CNT_W  current counter output Q
up  output  1  count-up strobe to the counter, one cycle wide
down  output  1  count-down strobe to the counter, one cycle wide
state_o  output  2  FSM state: 00 IDLE, 01 RUN_UP, 10 RUN_DOWN
busy  output  1  high when state is not IDLE

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state = IDLE; up, down, busy = 0; prescaler = 0.
  - Synchroniser and edge-detect flops are cleared to 0.
  - A button already held through reset release produces no edge.
- Input path, per button:
  - 2-flop synchroniser, then rising-edge detect against a third flop.
  - A press is a 1-cycle internal pulse: press_x = sync2 & ~prev.
  - A press changes state_o on the 3rd rising edge after the raw input is first sampled high.
- Press priority when presses coincide: stop > up > down.
- FSM transitions (registered):
  - IDLE: press_up -> RUN_UP; press_down -> RUN_DOWN.
  - RUN_UP: press_stop -> IDLE; press_down -> RUN_DOWN; press_up ignored (no prescaler restart).
  - RUN_DOWN: press_stop -> IDLE; press_up -> RUN_UP; press_down ignored.
  - Every entry into a RUN state, including a direction swap, clears the prescaler to 0.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN states; held at 0 in IDLE.
  - tick = (prescaler == PRESCALE-1); the prescaler wraps to 0 on tick.
  - Width is $clog2(PRESCALE).
- Strobes:
  - Registered. up (down) is high for exactly the one cycle after a tick in RUN_UP (RUN_DOWN).
  - First strobe appears PRESCALE+1 cycles after the state changes to RUN; after that, one strobe every PRESCALE cycles.
  - up & down is never 1. The counter's toggle logic misbehaves with both asserted, so this is a hard invariant.
- Limit handling, evaluated on tick using cnt_q (already settled, since PRESCALE >= 2):
  - LIMIT_STOP=1, RUN_UP, cnt_q == 2^CNT_W-1: no strobe, next state IDLE.
  - LIMIT_STOP=1, RUN_DOWN, cnt_q == 0: no strobe, next state IDLE.
  - LIMIT_STOP=0: strobe issued; the counter wraps (F->0, 0->F).
- Press vs tick in the same cycle: the press wins.
  - Stop: no strobe.
  - Direction swap: no strobe; the new direction's prescaler starts at 0.
- Reset mid-run: the next cycle shows IDLE with up = down = 0. Any pending strobe is dropped.
- busy = (state != IDLE), registered together with state.

Decomposition:
- Shared package counter_ctrl_pkg holds:
  - state encoding localparams ST_IDLE=2'b00, ST_RUN_UP=2'b01, ST_RUN_DOWN=2'b10;
  - DEFAULT_PRESCALE = 100000000.
- One natural sub-module, btn_sync_edge: 2-flop synchroniser plus rising-edge detect with synchronous reset. Instantiated three times.
- FSM, prescaler and strobe logic stay in counter_seq_ctrl. Expected size is about 150-250 lines.

Test Plan:
- Reset and basic up run (PRESCALE=4, LIMIT_STOP=1, counter instantiated, starts at 0):
  - stimulus: rst 2 cycles, then btn_up high 5 cycles;
  - response: state_o=01 three cycles after the press; first up pulse 5 cycles after that; counter reads 1,2,3 at 4-cycle spacing; down stays 0.
- Up limit stop:
  - stimulus: continue the up run;
  - response: counter reaches F; on the next tick no up pulse, state_o=00, busy=0; counter holds F.
- Down wrap (LIMIT_STOP=0, counter at 0):
  - stimulus: btn_down press;
  - response: first down pulse gives F, then E; state stays 10.
- Direction swap and priority:
  - stimulus: in RUN_UP, press btn_down together with btn_stop;
  - response: state_o=00 and no strobe. Separately, press down alone in RUN_UP: state 10, next strobe is down, PRESCALE+1 cycles later.
- Press on a tick cycle:
  - stimulus: align the btn_stop press so press_stop coincides with tick;
  - response: no up/down pulse; state IDLE.
- Reset mid-run:
  - stimulus: assert rst in the cycle a strobe is due;
  - response: up=down=0 the next cycle; state_o=00; a button held through reset does not restart the run.
- Throughout every test, an assertion checks that up & down is never 1.
